// File: rtl/snake_ctrl.sv
// Game sequencer for moving_snake: step tick, reversal-filtered direction, length/score, run/pause/over.
// All outputs registered (1-cycle latency); no backpressure, every input is a single-cycle pulse.
module snake_ctrl #(
  parameter int         TICK_DIV = 12500000,
  parameter logic [6:0] INIT_LEN = 7'd3,
  parameter logic [6:0] MAX_LEN  = 7'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir_valid,
  input  logic [1:0] dir_req,
  input  logic       food_eaten,
  input  logic       collision,
  output logic [1:0] di,
  output logic [6:0] len,
  output logic       move_tick,
  output logic [1:0] state,
  output logic       win,
  output logic [7:0] score
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } st_t;

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  st_t           st_q, st_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    pend_q, pend_d;
  logic [2:0]    grow_q, grow_d;
  logic [1:0]    di_d;
  logic [6:0]    len_d;
  logic          move_d;
  logic          win_d;
  logic [7:0]    score_d;
  logic [3:0]    grow_sum;

  always_comb begin
    st_d     = st_q;
    tick_d   = tick_q;
    pend_d   = pend_q;
    grow_d   = grow_q;
    di_d     = di;
    len_d    = len;
    move_d   = 1'b0;
    win_d    = win;
    score_d  = score;
    grow_sum = {1'b0, grow_q} + {3'b000, food_eaten};

    case (st_q)
      IDLE: begin
        tick_d = '0;
        if (start) st_d = RUN;
      end
      RUN: begin
        if (collision) begin
          st_d  = OVER;
          win_d = 1'b0;
        end else if (start) begin
          st_d = PAUSE;
        end else begin
          tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
          // Reversal is judged against the committed heading, not the pending one.
          if (dir_valid && (dir_req != (di ^ 2'b10))) pend_d = dir_req;
          if (food_eaten && (score != 8'hff)) score_d = score + 8'd1;
          if (tick_q == TICK_LAST) begin
            move_d = 1'b1;
            di_d   = pend_q;
            if ((grow_sum != 4'd0) && (len < MAX_LEN)) begin
              len_d    = len + 7'd1;
              grow_sum = grow_sum - 4'd1;
              if (len + 7'd1 == MAX_LEN) begin
                st_d  = OVER;
                win_d = 1'b1;
              end
            end
          end
          grow_d = (grow_sum > 4'd7) ? 3'd7 : grow_sum[2:0];
        end
      end
      PAUSE: begin
        if (start) st_d = RUN;
      end
      OVER: begin
        if (start) begin
          st_d    = IDLE;
          tick_d  = '0;
          pend_d  = 2'd1;
          grow_d  = 3'd0;
          di_d    = 2'd1;
          len_d   = INIT_LEN;
          win_d   = 1'b0;
          score_d = 8'd0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= IDLE;
      tick_q    <= '0;
      pend_q    <= 2'd1;
      grow_q    <= 3'd0;
      di        <= 2'd1;
      len       <= INIT_LEN;
      move_tick <= 1'b0;
      win       <= 1'b0;
      score     <= 8'd0;
    end else begin
      st_q      <= st_d;
      tick_q    <= tick_d;
      pend_q    <= pend_d;
      grow_q    <= grow_d;
      di        <= di_d;
      len       <= len_d;
      move_tick <= move_d;
      win       <= win_d;
      score     <= score_d;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Bench for snake_ctrl: directed game scenarios then random pulses, checked every cycle against a game-rule model.
module tb_snake_ctrl;

  localparam int TD = 4;
  localparam int IL = 3;
  localparam int ML = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic       food_eaten = 1'b0;
  logic       collision = 1'b0;
  logic [1:0] di;
  logic [6:0] len;
  logic       move_tick;
  logic [1:0] state;
  logic       win;
  logic [7:0] score;

  always #5 clk = ~clk;

  snake_ctrl #(
    .TICK_DIV(TD),
    .INIT_LEN(7'(IL)),
    .MAX_LEN (7'(ML))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir_valid (dir_valid),
    .dir_req   (dir_req),
    .food_eaten(food_eaten),
    .collision (collision),
    .di        (di),
    .len       (len),
    .move_tick (move_tick),
    .state     (state),
    .win       (win),
    .score     (score)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference game state: 0 idle, 1 run, 2 pause, 3 over.
  int m_state, m_di, m_pend, m_len, m_move, m_win, m_score, m_grow;
  int m_runcnt;  // RUN cycles that advanced the step timer this game

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_di = 1; m_pend = 1; m_len = IL; m_move = 0;
    m_win = 0; m_score = 0; m_grow = 0; m_runcnt = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit dv, input int dq,
                            input bit f, input bit c);
    int old_pend;
    bit due;
    if (r) begin
      model_reset();
      return;
    end
    m_move = 0;
    case (m_state)
      0: if (s) begin m_state = 1; m_runcnt = 0; end
      1: begin
        if (c) begin
          m_state = 3; m_win = 0;
        end else if (s) begin
          m_state = 2;
        end else begin
          m_runcnt++;
          due = (m_runcnt % TD) == 0;
          old_pend = m_pend;
          if (dv && dq != ((m_di + 2) % 4)) m_pend = dq;
          if (f) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            m_grow++;
          end
          if (due) begin
            m_move = 1;
            m_di = old_pend;
            if (m_grow > 0 && m_len < ML) begin
              m_len++;
              m_grow--;
              if (m_len == ML) begin m_state = 3; m_win = 1; end
            end
          end
          if (m_grow > 7) m_grow = 7;
        end
      end
      2: if (s) m_state = 1;
      default: if (s) model_reset();
    endcase
  endtask

  // One clock: inputs held across the edge, model advanced, outputs compared 1 time unit later.
  task automatic cyc(input bit r, input bit s, input bit dv, input int dq,
                     input bit f, input bit c);
    rst = r; start = s; dir_valid = dv; dir_req = 2'(dq); food_eaten = f; collision = c;
    @(posedge clk);
    model_step(r, s, dv, dq, f, c);
    #1;
    check("state", int'(state), m_state);
    check("di", int'(di), m_di);
    check("len", int'(len), m_len);
    check("move_tick", int'(move_tick), m_move);
    check("win", int'(win), m_win);
    check("score", int'(score), m_score);
    rst = 0; start = 0; dir_valid = 0; food_eaten = 0; collision = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Advance until the model's timer sits at phase ph (0..TD-1); TD-1 means the next edge ticks.
  task automatic wait_phase(input int ph);
    int k = 0;
    while ((m_runcnt % TD) != ph && k < 2 * TD) begin
      idle(1);
      k++;
    end
    check("phase_reached", m_runcnt % TD, ph);
  endtask

  initial begin
    model_reset();
    cyc(1, 0, 0, 0, 0, 0);
    idle(2);                       // IDLE holds
    cyc(0, 1, 0, 0, 0, 0);         // -> RUN
    idle(9);                       // ticks at 4 and 8 after entry
    cyc(0, 0, 1, 3, 0, 0);         // reverse of right: rejected
    wait_phase(TD - 1);
    idle(1);
    check("dir_rejected", int'(di), 1);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 2, 0, 0);         // last request wins
    wait_phase(TD - 1);
    idle(1);
    check("dir_last_wins", int'(di), 2);
    idle(1);
    cyc(0, 0, 0, 0, 1, 0);         // food mid-interval
    wait_phase(TD - 1);
    idle(1);
    check("grow_at_tick", int'(len), 4);
    wait_phase(TD - 1);
    cyc(0, 0, 0, 0, 1, 0);         // food on the tick edge -> win
    check("win_state", int'(state), 3);
    check("win_flag", int'(win), 1);
    idle(3);
    cyc(0, 1, 0, 0, 0, 0);         // OVER -> IDLE
    cyc(0, 1, 0, 0, 0, 0);         // IDLE -> RUN
    wait_phase(TD - 1);
    cyc(0, 0, 0, 0, 0, 1);         // collision when tick is due
    check("coll_no_tick", int'(move_tick), 0);
    idle(2);
    cyc(0, 1, 0, 0, 0, 0);
    check("restart_len", int'(len), IL);
    cyc(0, 1, 0, 0, 0, 0);
    wait_phase(2);
    cyc(0, 1, 0, 0, 0, 0);         // pause at phase 2
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, i % 4, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);         // resume
    idle(2);
    check("resume_tick", int'(move_tick), 1);
    idle(1);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(1, 0, 1, 2, 1, 0);         // reset overrides pending work
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 24) == 0,
          $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 3)),
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 39) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
